// File: rtl/weight_fetch_streamer.sv
// -----------------------------------------------------------------------------
// weight_fetch_streamer
//
// Read-side engine for the weight SRAM. A start command captures a base
// address and a word count. The engine then issues sequential reads on the
// SRAM read port, with the address wrapping modulo 2^ADDR_WIDTH. Returned words
// land in a small FIFO and are presented to the compute array on a valid/ready
// stream. Reads are issued only when a FIFO slot is guaranteed for the
// returning word, so the FIFO can never overflow.
//
// Ports:
//   clkb       in   single clock, shared with the SRAM read port
//   reset_n    in   asynchronous active-low reset
//   start      in   command pulse, sampled only in IDLE
//   base_addr  in   first word address, captured with start
//   num_words  in   word count 0..2^ADDR_WIDTH, captured with start
//   abort      in   cancel the current fetch (ignored outside FETCH)
//   busy       out  transfer in progress (FETCH or FLUSH)
//   done       out  one-cycle pulse on normal completion
//   enb        out  SRAM read enable (registered)
//   addrb      out  SRAM read address (registered)
//   doutb      in   SRAM read data, valid RD_LAT cycles after enb
//   m_valid    out  stream data valid
//   m_ready    in   stream consumer ready
//   m_data     out  weight word
//   m_last     out  high on the final word of a transfer
//   dbg_state  out  current FSM state (0 IDLE, 1 FETCH, 2 FLUSH)
// -----------------------------------------------------------------------------
module weight_fetch_streamer #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 256,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clkb,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [1:0]            dbg_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   WCNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [PW-1:0]         PTR_ONE  = PW'(1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [CW:0]           DEPTH_V  = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e                  state_q;
    logic                    enb_q;
    logic                    done_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     rem_issue_q;   // reads still to be issued
    logic [ADDR_WIDTH:0]     rem_pop_q;     // words still to be handed over
    logic [CW-1:0]           inflight_q;    // issued reads not yet written to the FIFO
    logic [CW-1:0]           fifo_cnt_q;
    logic [PW-1:0]           wr_ptr_q;
    logic [PW-1:0]           rd_ptr_q;
    logic [DATA_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [RD_LAT-1:0]       rv_q;          // return-valid shift register tracking enb

    logic                    pop;
    logic                    ret;
    logic                    fifo_wr;
    logic                    issue_d;
    logic [CW:0]             occ;
    logic [CW-1:0]           inflight_d;
    logic [CW-1:0]           fifo_cnt_d;

    // Stream handshake: a word moves in every cycle where m_valid and m_ready
    // are both high. While m_valid is high and m_ready is low, m_data and
    // m_last stay unchanged, because the FIFO head and rem_pop_q only change
    // on a pop. m_valid never drops without a pop, except on abort or reset.
    assign m_valid   = (state_q == ST_FETCH) && (fifo_cnt_q != '0);
    assign m_data    = fifo_mem_q[rd_ptr_q];
    assign m_last    = m_valid && (rem_pop_q == WCNT_ONE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign enb       = enb_q;
    assign addrb     = addr_q;
    assign dbg_state = state_q;

    always_comb begin
        pop     = m_valid & m_ready;
        ret     = rv_q[RD_LAT-1];
        // Data returning during the abort cycle or in FLUSH is dropped.
        fifo_wr = ret && (state_q == ST_FETCH) && !abort;

        // Slots already spoken for: stored words plus reads in flight. A word
        // popped this cycle frees its slot in time for the next issue.
        occ = {1'b0, fifo_cnt_q} + {1'b0, inflight_q} - {{CW{1'b0}}, pop};

        issue_d = 1'b0;
        case (state_q)
            ST_IDLE:  issue_d = start && (num_words != '0);
            ST_FETCH: issue_d = !abort && (rem_issue_q != '0) && (occ < DEPTH_V);
            default:  issue_d = 1'b0;
        endcase

        inflight_d = inflight_q;
        if (issue_d) begin
            inflight_d = inflight_d + CNT_ONE;
        end
        if (ret) begin
            inflight_d = inflight_d - CNT_ONE;
        end

        fifo_cnt_d = fifo_cnt_q;
        if (fifo_wr) begin
            fifo_cnt_d = fifo_cnt_d + CNT_ONE;
        end
        if (pop) begin
            fifo_cnt_d = fifo_cnt_d - CNT_ONE;
        end
    end

    always_ff @(posedge clkb or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            enb_q       <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            rem_issue_q <= '0;
            rem_pop_q   <= '0;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rv_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            done_q     <= 1'b0;
            enb_q      <= issue_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;

            // Reads issued before an abort still return; the shift register
            // keeps tracking them so FLUSH knows when the SRAM has gone quiet.
            rv_q[0] <= enb_q;
            for (int i = 1; i < RD_LAT; i++) begin
                rv_q[i] <= rv_q[i-1];
            end

            if (issue_d) begin
                if (state_q == ST_IDLE) begin
                    addr_q      <= base_addr;
                    rem_issue_q <= num_words - WCNT_ONE;
                end else begin
                    addr_q      <= addr_q + ADDR_ONE;
                    rem_issue_q <= rem_issue_q - WCNT_ONE;
                end
            end

            if (fifo_wr) begin
                fifo_mem_q[wr_ptr_q] <= doutb;
                wr_ptr_q             <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end

            case (state_q)
                ST_IDLE: begin
                    // start wins over a simultaneous abort here.
                    if (start) begin
                        if (num_words != '0) begin
                            state_q   <= ST_FETCH;
                            rem_pop_q <= num_words;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (abort) begin
                        // Later assignments override the FIFO updates above.
                        state_q    <= ST_FLUSH;
                        fifo_cnt_q <= '0;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                    end else if (pop) begin
                        rem_pop_q <= rem_pop_q - WCNT_ONE;
                        if (rem_pop_q == WCNT_ONE) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (inflight_q == '0) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fetch_streamer.sv
// Bench for weight_fetch_streamer. Two instances run side by side on the same
// stimulus, one with RD_LAT=1 and one with RD_LAT=2, each behind its own SRAM
// read-port model. SRAM word k holds word_of(k).
module tb_weight_fetch_streamer;

    localparam int AW = 11;
    localparam int DW = 256;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- shared stimulus ----------------
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          abort;
    logic          m_ready;

    // ---------------- per-instance outputs ----------------
    logic          busy_w    [2];
    logic          done_w    [2];
    logic          enb_w     [2];
    logic [AW-1:0] addrb_w   [2];
    logic [DW-1:0] doutb_w   [2];
    logic          m_valid_w [2];
    logic [DW-1:0] m_data_w  [2];
    logic          m_last_w  [2];
    logic [1:0]    dbg_w     [2];

    logic [DW-1:0] mem [2048];
    logic [DW-1:0] l1_r1;
    logic [DW-1:0] l2_r1;
    logic [DW-1:0] l2_r2;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return {8{21'h0, a}};
    endfunction

    always @(posedge clk) begin
        if (enb_w[0]) l1_r1 <= mem[addrb_w[0]];
        if (enb_w[1]) l2_r1 <= mem[addrb_w[1]];
        l2_r2 <= l2_r1;
    end
    assign doutb_w[0] = l1_r1;
    assign doutb_w[1] = l2_r2;

    weight_fetch_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1), .FIFO_DEPTH(4)) u_dut_l1 (
        .clkb(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .num_words(num_words), .abort(abort), .busy(busy_w[0]), .done(done_w[0]),
        .enb(enb_w[0]), .addrb(addrb_w[0]), .doutb(doutb_w[0]), .m_valid(m_valid_w[0]),
        .m_ready(m_ready), .m_data(m_data_w[0]), .m_last(m_last_w[0]), .dbg_state(dbg_w[0])
    );

    weight_fetch_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(2), .FIFO_DEPTH(4)) u_dut_l2 (
        .clkb(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .num_words(num_words), .abort(abort), .busy(busy_w[1]), .done(done_w[1]),
        .enb(enb_w[1]), .addrb(addrb_w[1]), .doutb(doutb_w[1]), .m_valid(m_valid_w[1]),
        .m_ready(m_ready), .m_data(m_data_w[1]), .m_last(m_last_w[1]), .dbg_state(dbg_w[1])
    );

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    int            n_checks;
    int            n_pass;

    int            enb_cnt   [2];
    int            done_cnt  [2];
    int            first_v   [2];
    int            done_cyc  [2];
    int            last_cyc  [2];
    int            iss_idx   [2];
    logic [AW-1:0] iss_base  [2];
    logic          prev_hold [2];
    logic [DW-1:0] prev_data [2];
    logic          prev_last [2];

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    // Per-cycle monitor for one instance, sampled on the falling edge.
    task automatic mon(input int k);
        string         sfx;
        logic [DW-1:0] e;
        logic [AW-1:0] ea;
        int            qs;
        int            occ;
        if (!reset_n) begin
            prev_hold[k] = 1'b0;
            return;
        end
        sfx = $sformatf("[lat%0d]", k + 1);
        if (enb_w[k]) begin
            enb_cnt[k]++;
            ea = iss_base[k] + AW'(iss_idx[k]);
            check_eq({"addrb", sfx}, addrb_w[k], ea);
            iss_idx[k]++;
        end
        if (m_valid_w[k] && prev_hold[k]) begin
            check_eq({"stall_data", sfx}, m_data_w[k], prev_data[k]);
            check_eq({"stall_last", sfx}, m_last_w[k], prev_last[k]);
        end
        if (m_valid_w[k] && first_v[k] < 0) first_v[k] = cyc;
        if (m_valid_w[k] && m_ready) begin
            qs = (k == 0) ? exp_q0.size() : exp_q1.size();
            check_eq({"have_exp", sfx}, qs != 0, 1);
            if (qs != 0) begin
                e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check_eq({"m_data", sfx}, m_data_w[k], e);
                check_eq({"m_last", sfx}, m_last_w[k], qs == 1);
            end
            if (m_last_w[k]) last_cyc[k] = cyc;
        end
        if (done_w[k]) begin
            done_cnt[k]++;
            done_cyc[k] = cyc;
            check_eq({"busy_at_done", sfx}, busy_w[k], 0);
        end
        occ = (k == 0) ? int'(u_dut_l1.fifo_cnt_q) + int'(u_dut_l1.inflight_q)
                       : int'(u_dut_l2.fifo_cnt_q) + int'(u_dut_l2.inflight_q);
        check_eq({"occupancy_le_4", sfx}, occ <= 4, 1);
        prev_hold[k] = m_valid_w[k] && !m_ready;
        prev_data[k] = m_data_w[k];
        prev_last[k] = m_last_w[k];
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // ---------------- driver tasks ----------------
    task automatic clear_track(input logic [AW-1:0] base);
        for (int k = 0; k < 2; k++) begin
            enb_cnt[k]  = 0;
            done_cnt[k] = 0;
            first_v[k]  = -1;
            done_cyc[k] = -1;
            last_cyc[k] = -1;
            iss_idx[k]  = 0;
            iss_base[k] = base;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            string sfx;
            sfx = $sformatf("%s[lat%0d]", tag, k + 1);
            check_eq({"busy_", sfx}, busy_w[k], 0);
            check_eq({"done_", sfx}, done_w[k], 0);
            check_eq({"enb_", sfx}, enb_w[k], 0);
            check_eq({"m_valid_", sfx}, m_valid_w[k], 0);
            check_eq({"m_last_", sfx}, m_last_w[k], 0);
            check_eq({"addrb_", sfx}, addrb_w[k], 0);
            check_eq({"m_data_", sfx}, m_data_w[k], 0);
        end
    endtask

    // mode 0: m_ready held high; mode 1: one cycle ready, three cycles stalled.
    task automatic run_xfer(input logic [AW-1:0] base, input logic [AW:0] num, input int mode,
                            input int restart_at, input bit with_abort);
        int            s;
        int            i;
        int            budget;
        logic [AW-1:0] a;
        string         sfx;
        clear_track(base);
        for (int w = 0; w < int'(num); w++) begin
            a = base + AW'(w);
            exp_q0.push_back(word_of(a));
            exp_q1.push_back(word_of(a));
        end
        start     = 1'b1;
        base_addr = base;
        num_words = num;
        abort     = with_abort;
        m_ready   = (mode == 0);
        @(posedge clk); #1;
        s     = cyc;
        start = 1'b0;
        abort = 1'b0;
        budget = 4 * int'(num) + 40;
        i = 0;
        while ((done_cnt[0] == 0 || done_cnt[1] == 0) && i < budget) begin
            m_ready = (mode == 0) ? 1'b1 : ((i % 4) == 0);
            if (i == restart_at) begin
                start     = 1'b1;
                base_addr = 11'd500;
                num_words = 12'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            i++;
        end
        start   = 1'b0;
        m_ready = 1'b0;
        check_eq($sformatf("no_timeout_b%0d_n%0d", base, num), i < budget, 1);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            sfx = $sformatf("_b%0d_n%0d[lat%0d]", base, num, k + 1);
            check_eq({"enb_cycles", sfx}, enb_cnt[k], num);
            check_eq({"done_pulses", sfx}, done_cnt[k], 1);
            check_eq({"words_left", sfx}, (k == 0) ? exp_q0.size() : exp_q1.size(), 0);
            check_eq({"busy_after", sfx}, busy_w[k], 0);
            if (num != '0) check_eq({"done_after_last", sfx}, done_cyc[k] - last_cyc[k], 1);
            else           check_eq({"done_latency", sfx}, done_cyc[k] - s, 0);
            if (mode == 0 && num != '0) check_eq({"first_valid", sfx}, first_v[k] - s, k + 2);
        end
    endtask

    task automatic run_abort();
        int i;
        clear_track(11'd40);
        m_ready   = 1'b0;
        start     = 1'b1;
        base_addr = 11'd40;
        num_words = 12'd20;
        @(posedge clk); #1;
        start = 1'b0;
        i = 0;
        while (enb_cnt[0] < 2 && i < 10) begin
            @(posedge clk); #1;
            i++;
        end
        // Third read is on the port now; abort stops any further issue.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("abort_m_valid[lat%0d]", k + 1), m_valid_w[k], 0);
            check_eq($sformatf("abort_busy[lat%0d]", k + 1), busy_w[k], 1);
            check_eq($sformatf("abort_enb[lat%0d]", k + 1), enb_w[k], 0);
            check_eq($sformatf("abort_state[lat%0d]", k + 1), dbg_w[k], 2);
        end
        i = 0;
        while ((busy_w[0] || busy_w[1]) && i < 12) begin
            @(posedge clk); #1;
            i++;
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("abort_drain_no_timeout", i < 12, 1);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("abort_issues[lat%0d]", k + 1), enb_cnt[k], 3);
            check_eq($sformatf("abort_no_done[lat%0d]", k + 1), done_cnt[k], 0);
            check_eq($sformatf("abort_idle[lat%0d]", k + 1), dbg_w[k], 0);
        end
    endtask

    task automatic run_reset_mid();
        clear_track(11'd100);
        m_ready   = 1'b0;
        start     = 1'b1;
        base_addr = 11'd100;
        num_words = 12'd30;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("pre_reset_valid[lat%0d]", k + 1), m_valid_w[k], 1);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int k = 0; k < 2048; k++) mem[k] = word_of(AW'(k));
        n_checks  = 0;
        n_pass    = 0;
        cyc       = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        abort     = 1'b0;
        m_ready   = 1'b0;
        for (int k = 0; k < 2; k++) prev_hold[k] = 1'b0;
        clear_track('0);
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_xfer(11'd10,   12'd5,    0, -1, 1'b0);  // basic fetch
        run_xfer(11'd200,  12'd16,   1, -1, 1'b0);  // backpressure
        run_xfer(11'd2046, 12'd4,    0, -1, 1'b0);  // address wrap
        run_xfer(11'd0,    12'd2048, 0, -1, 1'b0);  // full range
        run_xfer(11'd77,   12'd0,    0, -1, 1'b0);  // zero length
        run_xfer(11'd300,  12'd8,    0,  3, 1'b0);  // start mid-transfer ignored
        run_abort();
        run_xfer(11'd0,    12'd2,    0, -1, 1'b1);  // start with abort in IDLE
        run_reset_mid();
        run_xfer(11'd5,    12'd6,    1, -1, 1'b0);  // clean run after reset

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
